// File: rtl/apb_mem_ctrl.sv
// APB4 completer fronting a byte-addressable register-file memory.
// Latency: pready rises WaitStates+1 cycles into the access phase; outputs are registered.
// Backpressure: pready is held low while the wait counter runs; dropping psel/penable mid-access aborts it.
module apb_mem_ctrl #(
    parameter int unsigned NumWords   = 64,
    parameter int unsigned WaitStates = 2
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int unsigned AW = $clog2(NumWords);
    localparam logic [AW:0] LIMIT = (AW+1)'(NumWords);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETUP    = 2'd1;
    localparam logic [1:0] WAIT     = 2'd2;
    localparam logic [1:0] COMPLETE = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic          r_pready;
    logic          r_pslverr;
    logic [31:0]   r_prdata;
    logic [7:0]    r_mem [0:NumWords-1];

    logic [1:0]    w_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    w_cnt_nxt;
    logic          w_setup;
    logic [1:0]    w_hi;
    logic          w_oor;
    logic [AW:0]   w_end_wr;
    logic [AW:0]   w_end_rd;
    logic          w_err_live;
    logic [AW-1:0] w_off;
    logic          w_wr;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;
    logic          w_err;
    logic          w_commit;
    logic [31:0]   w_rd_dat;

    // The APB setup cycle is the SETUP state: it is visible combinationally
    // so that a zero-wait transfer can complete on the first access cycle.
    always_comb begin
        w_state = r_state;
        if (r_state == IDLE && psel && !penable) begin
            w_state = SETUP;
        end
    end

    assign w_setup = (w_state == SETUP);

    // Highest enabled write lane; zero strobes collapse to lane 0, which never overflows.
    always_comb begin
        w_hi = 2'd0;
        if (pstrb[3])      w_hi = 2'd3;
        else if (pstrb[2]) w_hi = 2'd2;
        else if (pstrb[1]) w_hi = 2'd1;
    end

    // Span checks use one extra bit so an overflowing span cannot wrap to a legal offset.
    assign w_oor      = |paddr[31:AW];
    assign w_end_wr   = {1'b0, paddr[AW-1:0]} + (AW+1)'(w_hi);
    assign w_end_rd   = {1'b0, paddr[AW-1:0]} + (AW+1)'(3);
    assign w_err_live = w_oor | (pwrite ? (w_end_wr >= LIMIT) : (w_end_rd >= LIMIT));

    // During SETUP the live bus is used (zero-wait commits on that same edge);
    // afterwards only the latched copy matters, so later bus changes are ignored.
    assign w_off   = w_setup ? paddr[AW-1:0] : r_addr;
    assign w_wr    = w_setup ? pwrite        : r_wr;
    assign w_strb  = w_setup ? pstrb         : r_strb;
    assign w_wdata = w_setup ? pwdata        : r_wdata;
    assign w_err   = w_setup ? w_err_live    : r_err;

    assign w_rd_dat = {r_mem[w_off + AW'(3)], r_mem[w_off + AW'(2)],
                       r_mem[w_off + AW'(1)], r_mem[w_off]};

    // Next-state and wait-counter decision.
    always_comb begin
        w_state_nxt = w_state;
        w_cnt_nxt   = r_cnt;
        case (w_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            SETUP: begin
                w_cnt_nxt   = 4'(WaitStates);
                w_state_nxt = (WaitStates == 0) ? COMPLETE : WAIT;
            end
            WAIT: begin
                if (psel && penable) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = COMPLETE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Entering COMPLETE is the single point where memory and outputs are updated.
    assign w_commit = (w_state_nxt == COMPLETE) && (w_state != COMPLETE);

    // Control state, transfer latch and registered response.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_strb    <= 4'd0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_setup) begin
                r_addr  <= paddr[AW-1:0];
                r_wr    <= pwrite;
                r_strb  <= pstrb;
                r_wdata <= pwdata;
                r_err   <= w_err_live;
            end
            r_pready  <= w_commit;
            r_pslverr <= w_commit & w_err;
            r_prdata  <= (w_commit && !w_err && !w_wr) ? w_rd_dat : 32'd0;
        end
    end

    // Byte-lane write commit; reset clears the whole array and drops any pending write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_commit && w_wr && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_off + AW'(i)] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule
